// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared state encoding and default width for the sequential divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/full_subtractor_nb.sv
// ============================================================================
// Module  : full_subtractor_nb
// Purpose : n-bit ripple-borrow subtractor, diff = a - b - bin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_subtractor_nb #(
  parameter int n = 9
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic [n-1:0] diff,
  output logic         bout
);

  logic [n:0] w_br;

  assign w_br[0] = bin;

  generate
    for (genvar i = 0; i < n; i++) begin : g_bit
      assign diff[i]    = a[i] ^ b[i] ^ w_br[i];
      assign w_br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
    end
  endgenerate

  assign bout = w_br[n];

endmodule : full_subtractor_nb

`default_nettype wire

// File: rtl/divider_seq.sv
// ============================================================================
// Module  : divider_seq
// Purpose : Unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divider_seq
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     w_shift;
  logic [N:0]     w_diff;
  logic           w_bout;

  // Top bit of the shifted remainder drops out; it is always zero after a step.
  assign w_shift = (rem_q << 1) | {{N{1'b0}}, dvd_q[N-1]};

  full_subtractor_nb #(
    .n (N + 1)
  ) u_sub (
    .a    (w_shift),
    .b    ({1'b0, dvs_q}),
    .bin  (1'b0),
    .diff (w_diff),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          quo_d = '0;
          rem_d = '0;
          cnt_d = CW'(N);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[N-2:0], ~w_bout};
        rem_d = w_bout ? w_shift : w_diff;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        if (cnt_q <= CW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q[N-1:0];
  assign div_by_zero = dbz_q;

endmodule : divider_seq

`default_nettype wire

// File: tb/tb_divider_seq.sv
// ============================================================================
// Module  : tb_divider_seq
// Purpose : Directed and random checks of divider_seq at N = 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_divider_seq;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  divider_seq #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts one division from IDLE and checks latency, results and the return to IDLE.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                       input logic exp_z, input int exp_lat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_z);
    check("busy_in_done", busy, 1'b1);
    @(posedge clk);
    #1;
    check("done_pulse_end", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("quotient_hold", quotient, exp_q);
  endtask

  initial begin
    logic [N-1:0] ra, rb, rq, rr;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    do_op(8'd3, 8'd9, 8'd0, 8'd3, 1'b0, 9);
    do_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
    do_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);

    // Idle with start low: outputs hold
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_q", quotient, 8'd3);
    check("idle_hold_r", remainder, 8'd1);
    check("idle_busy", busy, 1'b0);

    // start held high, operands disturbed mid-run, then back-to-back acceptance
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    check("hold_accept_busy", busy, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd55;
    divisor  = 8'd3;
    begin
      int lat;
      lat = 4;
      while (!done && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("hold_latency", lat, 9);
    end
    check("hold_quotient", quotient, 8'd15);
    check("hold_remainder", remainder, 8'd5);
    @(posedge clk);
    #1;
    check("hold_ignored_in_done", busy, 1'b0);
    check("hold_q_kept", quotient, 8'd15);
    @(posedge clk);
    #1;
    check("hold_reaccept", busy, 1'b1);
    start = 1'b0;
    begin
      int lat;
      lat = 1;
      while (!done && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("b2b_latency", lat, 9);
    end
    check("b2b_quotient", quotient, 8'd18);
    check("b2b_remainder", remainder, 8'd1);
    @(posedge clk);
    #1;

    // Reset during RUN cycle 4 of 100/7
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_quotient", quotient, 0);
    check("arst_remainder", remainder, 0);
    check("arst_dbz", div_by_zero, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_no_done", done, 1'b0);
    check("arst_still_idle", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rb == 0) begin
        do_op(ra, rb, 8'hFF, ra, 1'b1, 1);
      end else begin
        rq = ra / rb;
        rr = ra % rb;
        do_op(ra, rb, rq, rr, 1'b0, 9);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_divider_seq

`default_nettype wire
